// File: rtl/pic_overlay_pkg.sv
// Shared types for the picture-overlay sequencer: FSM states, full-scale alpha
// and the 12-bit RGB colour struct.
package pic_overlay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FADE_IN = 2'd2,
    ST_SHOW    = 2'd3
  } ovl_state_t;

  localparam logic [4:0] ALPHA_MAX = 5'd16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

endpackage

// File: rtl/pic_overlay_ctrl_if.sv
// Scan, ROM, palette and colour-output signals of the overlay controller.
// slave is the controller side; master is the VGA/ROM/palette side.
interface pic_overlay_ctrl_if #(
  parameter int AW = 17
);
  logic          frame_start;
  logic          show_req;
  logic [9:0]    DrawX;
  logic [9:0]    DrawY;
  logic          blank;
  logic [11:0]   bg_rgb;
  logic [AW-1:0] rom_addr;
  logic [4:0]    rom_index;
  logic [4:0]    pal_index;
  logic [11:0]   pal_rgb;
  logic [3:0]    red;
  logic [3:0]    green;
  logic [3:0]    blue;
  logic          overlay_on;

  modport master (
    output frame_start, show_req, DrawX, DrawY, blank, bg_rgb, rom_index, pal_rgb,
    input  rom_addr, pal_index, red, green, blue, overlay_on
  );

  modport slave (
    input  frame_start, show_req, DrawX, DrawY, blank, bg_rgb, rom_index, pal_rgb,
    output rom_addr, pal_index, red, green, blue, overlay_on
  );
endinterface

// File: rtl/pic_overlay_ctrl_blend.sv
// Combinational per-channel alpha blend: (pic*alpha + bg*(16-alpha)) >> 4.
module rgb_blend
  import pic_overlay_pkg::*;
(
  input  rgb12_t     pic,
  input  rgb12_t     bg,
  input  logic [4:0] alpha,
  output rgb12_t     mix
);

  // Worst case 15*16 = 240, so an 8-bit sum never overflows.
  function automatic logic [3:0] blend_ch(input logic [3:0] p, input logic [3:0] b,
                                          input logic [4:0] a);
    logic [4:0] inv_a;
    logic [7:0] sum;
    inv_a = ALPHA_MAX - a;
    sum   = 8'(p) * 8'(a) + 8'(b) * 8'(inv_a);
    return 4'(sum >> 4);
  endfunction

  assign mix.r = blend_ch(pic.r, bg.r, alpha);
  assign mix.g = blend_ch(pic.g, bg.g, alpha);
  assign mix.b = blend_ch(pic.b, bg.b, alpha);

endmodule

// File: rtl/pic_overlay_ctrl.sv
// Full-screen picture overlay sequencer for the board's VGA output.
// Build option: define PIC_OVERLAY_FADE_EN for the 17-frame fade-in.
module pic_overlay_ctrl
  import pic_overlay_pkg::*;
#(
  parameter int PIC_W           = 320,
  parameter int PIC_H           = 240,
  parameter int X0              = 160,
  parameter int Y0              = 120,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  pic_overlay_ctrl_if.slave bus
);

  localparam int            AW        = $clog2(PIC_W * PIC_H);
  localparam logic [10:0]   X_LO      = 11'(X0);
  localparam logic [10:0]   X_HI      = 11'(X0 + PIC_W);
  localparam logic [10:0]   Y_LO      = 11'(Y0);
  localparam logic [10:0]   Y_HI      = 11'(Y0 + PIC_H);
  localparam logic [AW-1:0] ADDR_LAST = AW'(PIC_W * PIC_H - 1);
  localparam logic [4:0]    TRANSP    = 5'(TRANSPARENT_IDX);

  ovl_state_t    state_r, state_nxt_s;
  logic [4:0]    alpha_r, alpha_nxt_s;
  logic          overlay_r;
  logic          in_win_s;
  logic [AW-1:0] cnt_r, addr_r;
  logic [2:0]    win_sr_r, blank_sr_r;
  rgb12_t        bg1_r, bg2_r, bg3_r;
  rgb12_t        pal_r;
  logic          transp_r;
  rgb12_t        pic_s, mix_s, out_nxt_s, rgb_r;

  assign in_win_s = ({1'b0, bus.DrawX} >= X_LO) && ({1'b0, bus.DrawX} < X_HI) &&
                    ({1'b0, bus.DrawY} >= Y_LO) && ({1'b0, bus.DrawY} < Y_HI) && bus.blank;

  // Scan pipeline: address counter, ROM address and the aligned side-band delay lines.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_r      <= '0;
      addr_r     <= '0;
      win_sr_r   <= 3'b000;
      blank_sr_r <= 3'b000;
      bg1_r      <= '0;
      bg2_r      <= '0;
      bg3_r      <= '0;
      pal_r      <= '0;
      transp_r   <= 1'b0;
    end else begin
      if (bus.frame_start) begin
        cnt_r  <= '0;
        addr_r <= '0;
      end else if (in_win_s) begin
        addr_r <= cnt_r;
        // Saturates on the last picture pixel instead of wrapping.
        if (cnt_r != ADDR_LAST) cnt_r <= cnt_r + AW'(1);
      end
      win_sr_r   <= {win_sr_r[1:0], in_win_s};
      blank_sr_r <= {blank_sr_r[1:0], bus.blank};
      bg1_r      <= bus.bg_rgb;
      bg2_r      <= bg1_r;
      bg3_r      <= bg2_r;
      pal_r      <= bus.pal_rgb;
      transp_r   <= (bus.rom_index == TRANSP);
    end
  end

  assign bus.rom_addr  = addr_r;
  assign bus.pal_index = bus.rom_index;

  // Overlay state register; alpha and overlay_on follow the next state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= ST_IDLE;
      alpha_r   <= 5'd0;
      overlay_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      alpha_r   <= alpha_nxt_s;
      overlay_r <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state logic: everything except ARMED entry/cancel waits for frame_start.
  always_comb begin
    state_nxt_s = state_r;
    alpha_nxt_s = alpha_r;
    case (state_r)
      ST_IDLE: begin
        alpha_nxt_s = 5'd0;
        if (bus.show_req) begin
          state_nxt_s = ST_ARMED;
`ifdef PIC_OVERLAY_FADE_EN
          alpha_nxt_s = 5'd0;
`else
          alpha_nxt_s = ALPHA_MAX;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!bus.show_req) begin
          state_nxt_s = ST_IDLE;
          alpha_nxt_s = 5'd0;
        end else if (bus.frame_start) begin
`ifdef PIC_OVERLAY_FADE_EN
          state_nxt_s = ST_FADE_IN;
          alpha_nxt_s = 5'd0;
`else
          state_nxt_s = ST_SHOW;
          alpha_nxt_s = ALPHA_MAX;
`endif
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_FADE_IN: begin
        if (!bus.frame_start) begin
          state_nxt_s = ST_FADE_IN;
        end else if (!bus.show_req) begin
          state_nxt_s = ST_IDLE;
          alpha_nxt_s = 5'd0;
        end else if (alpha_r == ALPHA_MAX) begin
          state_nxt_s = ST_SHOW;
        end else begin
          alpha_nxt_s = alpha_r + 5'd1;
        end
      end
      ST_SHOW: begin
        if (bus.frame_start && !bus.show_req) begin
          state_nxt_s = ST_IDLE;
          alpha_nxt_s = 5'd0;
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        alpha_nxt_s = 5'd0;
      end
    endcase
  end

  // Picture colour: transparent index or out-of-window pixels fall back to the board.
  always_comb begin
    pic_s = bg3_r;
    if (transp_r || !win_sr_r[2]) begin
      pic_s = bg3_r;
    end else begin
      pic_s = pal_r;
    end
  end

`ifdef PIC_OVERLAY_FADE_EN
  rgb_blend u_blend (
    .pic   (pic_s),
    .bg    (bg3_r),
    .alpha (alpha_r),
    .mix   (mix_s)
  );
`else
  // Without fading alpha is pinned at full scale while the overlay is active.
  assign mix_s = (alpha_r == ALPHA_MAX) ? pic_s : bg3_r;
`endif

  // Output select: blanking forces black, inactive overlay passes the board colour.
  always_comb begin
    out_nxt_s = '0;
    if (!blank_sr_r[2]) begin
      out_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ARMED:   out_nxt_s = bg3_r;
        ST_FADE_IN, ST_SHOW: out_nxt_s = mix_s;
        default:             out_nxt_s = bg3_r;
      endcase
    end
  end

  // Colour output register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_r <= '0;
    end else begin
      rgb_r <= out_nxt_s;
    end
  end

  assign bus.red        = rgb_r.r;
  assign bus.green      = rgb_r.g;
  assign bus.blue       = rgb_r.b;
  assign bus.overlay_on = overlay_r;

endmodule

// File: tb/tb_pic_overlay_ctrl.sv
// Directed bench for pic_overlay_ctrl with a constant-index ROM model and a
// small combinational palette (index 3 -> 12'h79B).
module tb_pic_overlay_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rom_sel;
  int         checks;
  int         errors;

`ifdef PIC_OVERLAY_FADE_EN
  localparam int SHOW_PULSES = 17;
`else
  localparam int SHOW_PULSES = 0;
`endif

  pic_overlay_ctrl_if #(.AW(17)) bus ();

  pic_overlay_ctrl dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rom_index <= 5'd0;
    else        bus.rom_index <= rom_sel;
  end

  always_comb begin
    case (bus.pal_index)
      5'd0:    bus.pal_rgb = 12'hABC;
      5'd3:    bus.pal_rgb = 12'h79B;
      default: bus.pal_rgb = 12'h5A5;
    endcase
  end

  function automatic logic [11:0] rgb_out();
    return {bus.red, bus.green, bus.blue};
  endfunction

  task automatic set_px(input int x, input int y, input logic bl, input logic [11:0] bg);
    bus.DrawX  = 10'(x);
    bus.DrawY  = 10'(y);
    bus.blank  = bl;
    bus.bg_rgb = bg;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    bus.blank       = 1'b0;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.show_req    = 1'b0;
    rom_sel         = 5'd0;
    set_px(10, 10, 1'b0, 12'h123);
    hold(3);
    checks++;
    if (rgb_out() !== 12'h000) begin
      errors++; $display("FAIL reset_rgb got %h want 000", rgb_out());
    end
    checks++;
    if (bus.rom_addr !== 17'd0) begin
      errors++; $display("FAIL reset_addr got %0d want 0", bus.rom_addr);
    end
    rst_n = 1'b1;
    hold(5);
    checks++;
    if (rgb_out() !== 12'h000) begin
      errors++; $display("FAIL idle_blanked got %h want 000", rgb_out());
    end
    set_px(10, 10, 1'b1, 12'h123);
    hold(3);
    checks++;
    if (rgb_out() !== 12'h000) begin
      errors++; $display("FAIL latency_early got %h want 000", rgb_out());
    end
    hold(1);
    checks++;
    if (rgb_out() !== 12'h123) begin
      errors++; $display("FAIL latency_3 got %h want 123", rgb_out());
    end
    checks++;
    if (bus.overlay_on !== 1'b0) begin
      errors++; $display("FAIL idle_overlay got %b want 0", bus.overlay_on);
    end
  endtask

  task automatic test_address();
    int bad;
    bad = 0;
    frame_pulse();
    for (int y = 120; y < 360; y++) begin
      for (int x = 160; x < 480; x++) begin
        set_px(x, y, 1'b1, 12'h000);
        @(negedge clk);
        if (bus.rom_addr !== 17'((y - 120) * 320 + (x - 160))) bad++;
        if ((x == 160 && y == 120) || (x == 479 && y == 120) || (x == 160 && y == 121)) begin
          checks++;
          if (bus.rom_addr !== 17'((y - 120) * 320 + (x - 160))) begin
            errors++;
            $display("FAIL addr_point x=%0d y=%0d got %0d want %0d", x, y, bus.rom_addr,
                     (y - 120) * 320 + (x - 160));
          end
        end
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL addr_sweep got %0d bad pixels want 0", bad);
    end
    checks++;
    if (bus.rom_addr !== 17'd76799) begin
      errors++; $display("FAIL addr_last got %0d want 76799", bus.rom_addr);
    end
    set_px(480, 359, 1'b1, 12'h000);
    hold(3);
    set_px(200, 200, 1'b1, 12'h000);
    hold(3);
    checks++;
    if (bus.rom_addr !== 17'd76799) begin
      errors++; $display("FAIL addr_hold got %0d want 76799", bus.rom_addr);
    end
    frame_pulse();
    checks++;
    if (bus.rom_addr !== 17'd0) begin
      errors++; $display("FAIL addr_clear got %0d want 0", bus.rom_addr);
    end
  endtask

  task automatic test_armed_cancel();
    bus.show_req = 1'b1;
    hold(1);
    checks++;
    if (bus.overlay_on !== 1'b1) begin
      errors++; $display("FAIL armed_on got %b want 1", bus.overlay_on);
    end
    bus.show_req = 1'b0;
    hold(1);
    checks++;
    if (bus.overlay_on !== 1'b0) begin
      errors++; $display("FAIL armed_cancel got %b want 0", bus.overlay_on);
    end
  endtask

  task automatic test_same_cycle();
    rom_sel = 5'd3;
    bus.show_req = 1'b1;
    frame_pulse();
    checks++;
    if (bus.overlay_on !== 1'b1) begin
      errors++; $display("FAIL same_cycle_on got %b want 1", bus.overlay_on);
    end
    set_px(200, 200, 1'b1, 12'h456);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h456) begin
      errors++; $display("FAIL same_cycle_armed got %h want 456", rgb_out());
    end
  endtask

`ifdef PIC_OVERLAY_FADE_EN
  task automatic test_fade();
    frame_pulse();
    set_px(200, 200, 1'b1, 12'h000);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h000) begin
      errors++; $display("FAIL fade_a0 got %h want 000", rgb_out());
    end
    repeat (8) frame_pulse();
    set_px(200, 200, 1'b1, 12'h000);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h345) begin
      errors++; $display("FAIL fade_a8 got %h want 345", rgb_out());
    end
    set_px(200, 200, 1'b1, 12'h246);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h468) begin
      errors++; $display("FAIL fade_a8_bg got %h want 468", rgb_out());
    end
    repeat (8) frame_pulse();
    set_px(200, 200, 1'b1, 12'h000);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h79B) begin
      errors++; $display("FAIL fade_a16 got %h want 79b", rgb_out());
    end
    frame_pulse();
    set_px(200, 200, 1'b1, 12'h246);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h79B) begin
      errors++; $display("FAIL fade_show got %h want 79b", rgb_out());
    end
  endtask
`else
  task automatic test_show_direct();
    frame_pulse();
    set_px(200, 200, 1'b1, 12'h456);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h79B) begin
      errors++; $display("FAIL direct_show got %h want 79b", rgb_out());
    end
  endtask
`endif

  task automatic test_transparency();
    rom_sel = 5'd0;
    set_px(200, 200, 1'b1, 12'hF00);
    hold(5);
    checks++;
    if (rgb_out() !== 12'hF00) begin
      errors++; $display("FAIL transparent got %h want f00", rgb_out());
    end
    rom_sel = 5'd3;
    set_px(10, 10, 1'b1, 12'h0F0);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h0F0) begin
      errors++; $display("FAIL outside_win got %h want 0f0", rgb_out());
    end
    set_px(479, 359, 1'b1, 12'h0F0);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h79B) begin
      errors++; $display("FAIL win_corner got %h want 79b", rgb_out());
    end
    set_px(480, 200, 1'b1, 12'h0F0);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h0F0) begin
      errors++; $display("FAIL win_right got %h want 0f0", rgb_out());
    end
    set_px(200, 360, 1'b1, 12'h00F);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h00F) begin
      errors++; $display("FAIL win_bottom got %h want 00f", rgb_out());
    end
    set_px(159, 200, 1'b1, 12'h0F0);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h0F0) begin
      errors++; $display("FAIL win_left got %h want 0f0", rgb_out());
    end
    set_px(200, 200, 1'b0, 12'h0F0);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h000) begin
      errors++; $display("FAIL show_blanked got %h want 000", rgb_out());
    end
  endtask

  task automatic test_dismiss();
    logic [11:0] exp_rgb;
    bus.show_req = 1'b0;
    set_px(200, 200, 1'b1, 12'h456);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h79B) begin
      errors++; $display("FAIL dismiss_wait got %h want 79b", rgb_out());
    end
    frame_pulse();
    checks++;
    if (bus.overlay_on !== 1'b0) begin
      errors++; $display("FAIL dismiss_idle got %b want 0", bus.overlay_on);
    end
    set_px(200, 200, 1'b1, 12'h456);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h456) begin
      errors++; $display("FAIL dismiss_bg got %h want 456", rgb_out());
    end
    bus.show_req = 1'b1;
    hold(1);
    frame_pulse();
    set_px(200, 200, 1'b1, 12'h456);
    hold(5);
`ifdef PIC_OVERLAY_FADE_EN
    exp_rgb = 12'h456;
`else
    exp_rgb = 12'h79B;
`endif
    checks++;
    if (rgb_out() !== exp_rgb) begin
      errors++; $display("FAIL rearm_alpha got %h want %h", rgb_out(), exp_rgb);
    end
  endtask

  task automatic test_reset_midframe();
    repeat (SHOW_PULSES) frame_pulse();
    set_px(300, 200, 1'b1, 12'h456);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h79B) begin
      errors++; $display("FAIL pre_reset got %h want 79b", rgb_out());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rgb_out() !== 12'h000) begin
      errors++; $display("FAIL midreset_rgb got %h want 000", rgb_out());
    end
    checks++;
    if (bus.overlay_on !== 1'b0) begin
      errors++; $display("FAIL midreset_overlay got %b want 0", bus.overlay_on);
    end
    checks++;
    if (bus.rom_addr !== 17'd0) begin
      errors++; $display("FAIL midreset_addr got %0d want 0", bus.rom_addr);
    end
    bus.show_req = 1'b0;
    hold(2);
    rst_n = 1'b1;
    frame_pulse();
    set_px(300, 200, 1'b1, 12'h456);
    hold(5);
    checks++;
    if (rgb_out() !== 12'h456) begin
      errors++; $display("FAIL post_reset got %h want 456", rgb_out());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_address();
    test_armed_cancel();
    test_same_cycle();
`ifdef PIC_OVERLAY_FADE_EN
    test_fade();
`else
    test_show_direct();
`endif
    test_transparency();
    test_dismiss();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
